// File: rtl/ifetch_queue.sv
// Fetch stage: drives fetch_pc to the icache, queues acked instructions with their PC
// in a small FIFO for decode, and flushes/restarts on pipeline redirects.
module ifetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] fetch_pc,
  input  logic [31:0] icache_instr,
  input  logic        icache_ack,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull       = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAlmostFull = CntW'(DEPTH - 1);

  typedef enum logic [1:0] {StFetch, StStall, StSquash} state_e;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [63:0]      pc_mem_q    [DEPTH];
  logic             push;
  logic             pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    push    = 1'b0;
    pop     = (cnt_q != '0) && dec_ready;

    unique case (state_q)
      StFetch: begin
        // An ack while full is dropped; the PC is held so it gets refetched.
        if (icache_ack && (cnt_q != CntFull)) begin
          push = 1'b1;
          pc_d = pc_q + 64'd4;
          if (!pop && (cnt_q == CntAlmostFull)) state_d = StStall;
        end
      end
      StStall: begin
        if (pop) state_d = StFetch;
      end
      StSquash: begin
        state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (push) wr_d = wr_q + PtrW'(1);
    if (pop)  rd_d = rd_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Redirect wins over any same-cycle push/pop; SQUASH shields against a stale ack.
    if (redirect_valid) begin
      push    = 1'b0;
      pop     = 1'b0;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = redirect_pc & ~64'h3;
      state_d = StSquash;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) begin
        instr_mem_q[wr_q] <= icache_instr;
        pc_mem_q[wr_q]    <= pc_q;
      end
    end
  end

  assign fetch_pc  = pc_q;
  assign dec_valid = (cnt_q != '0);
  assign dec_instr = instr_mem_q[rd_q];
  assign dec_pc    = pc_mem_q[rd_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (RESET_PC=0x1000, DEPTH=4).
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fetch_pc;
  logic [31:0] icache_instr;
  logic        icache_ack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_ready;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(
    .RESET_PC(64'h1000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .icache_instr  (icache_instr),
    .icache_ack    (icache_ack),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(dec_valid), 64'h1);
    chk({tag, "_pc"}, dec_pc, pc);
    chk({tag, "_instr"}, 64'(dec_instr), 64'(mk(pc)));
  endtask

  initial begin
    reset          = 1'b1;
    icache_ack     = 1'b0;
    icache_instr   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    step();
    step();
    chk("rst_fetch_pc", fetch_pc, 64'h1000);
    chk("rst_dec_valid", 64'(dec_valid), 64'h0);
    chk("rst_dec_pc", dec_pc, 64'h0);
    chk("rst_dec_instr", 64'(dec_instr), 64'h0);

    // Streaming: ack every cycle, decode always ready.
    reset      = 1'b0;
    dec_ready  = 1'b1;
    icache_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      icache_instr = mk(64'h1000 + 64'(4 * i));
      step();
      chk_head("stream", 64'h1000 + 64'(4 * i));
      chk("stream_fetch_pc", fetch_pc, 64'h1004 + 64'(4 * i));
    end
    icache_ack = 1'b0;
    step();
    chk("stream_drain", 64'(dec_valid), 64'h0);

    // Fill to full with decode stalled; extra acks must be dropped.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    dec_ready  = 1'b0;
    icache_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      icache_instr = mk(64'h1000 + 64'(4 * (i < 4 ? i : 4)));
      step();
    end
    chk("full_fetch_pc", fetch_pc, 64'h1010);
    chk_head("full_head", 64'h1000);
    dec_ready    = 1'b1;
    icache_instr = mk(64'h1010);
    step();
    chk_head("stall_pop", 64'h1004);
    chk("stall_pop_fetch_pc", fetch_pc, 64'h1010);
    step();
    chk_head("refetch", 64'h1008);
    chk("refetch_fetch_pc", fetch_pc, 64'h1014);
    icache_ack = 1'b0;
    step();
    chk_head("order0", 64'h100C);
    step();
    chk_head("order1", 64'h1010);
    step();
    chk("order_empty", 64'(dec_valid), 64'h0);

    // Redirect with 3 queued entries and a simultaneous ack.
    dec_ready  = 1'b0;
    icache_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      icache_instr = mk(64'h1014 + 64'(4 * i));
      step();
    end
    chk_head("pre_redir", 64'h1014);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    icache_instr   = mk(64'h1020);
    step();
    chk("redir_flush", 64'(dec_valid), 64'h0);
    chk("redir_fetch_pc", fetch_pc, 64'h2000);
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    icache_instr   = 32'hDEAD_BEEF;
    step();
    chk("squash_ignore", 64'(dec_valid), 64'h0);
    chk("squash_fetch_pc", fetch_pc, 64'h2000);
    icache_instr = mk(64'h2000);
    step();
    chk_head("post_redir", 64'h2000);
    chk("post_redir_fetch_pc", fetch_pc, 64'h2004);
    icache_ack = 1'b0;
    step();
    chk("post_redir_empty", 64'(dec_valid), 64'h0);

    // count = DEPTH-1 with push+pop: must stay in FETCH with room for one more.
    dec_ready  = 1'b0;
    icache_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      icache_instr = mk(64'h2004 + 64'(4 * i));
      step();
    end
    dec_ready    = 1'b1;
    icache_instr = mk(64'h2010);
    step();
    chk_head("pushpop", 64'h2008);
    chk("pushpop_fetch_pc", fetch_pc, 64'h2014);
    dec_ready    = 1'b0;
    icache_instr = mk(64'h2014);
    step();
    chk("fill4_fetch_pc", fetch_pc, 64'h2018);
    icache_instr = mk(64'h2018);
    step();
    chk("drop_fetch_pc", fetch_pc, 64'h2018);
    chk_head("drop_head", 64'h2008);

    // Reset while stalled with a full FIFO.
    reset      = 1'b1;
    icache_ack = 1'b0;
    step();
    chk("midrst_valid", 64'(dec_valid), 64'h0);
    chk("midrst_fetch_pc", fetch_pc, 64'h1000);
    chk("midrst_dec_pc", dec_pc, 64'h0);
    reset        = 1'b0;
    icache_ack   = 1'b1;
    icache_instr = mk(64'h1000);
    step();
    chk_head("midrst_fetch", 64'h1000);
    chk("midrst_next_pc", fetch_pc, 64'h1004);

    // PC wraparound; redirect low bits are forced to zero.
    icache_ack     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("wrap_redir_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_flush", 64'(dec_valid), 64'h0);
    redirect_valid = 1'b0;
    step();
    dec_ready    = 1'b1;
    icache_ack   = 1'b1;
    icache_instr = mk(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_fetch_pc", fetch_pc, 64'h0);
    chk_head("wrap_head", 64'hFFFF_FFFF_FFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
